// File: rtl/arbitro_rr_onehot.sv
// Four-way round-robin arbiter: one-hot rotating pointer, registered grant, hold quantum, one-cycle gap.
// Optional macro ARB_TIMEOUT_EN: ends a grant when hold_cnt reaches MAX_HOLD.
module arbitro_rr_onehot #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [3:0]    req_i,
    input  logic          release_i,
    input  logic          ptr_load_i,
    input  logic [3:0]    ptr_value_i,
    output logic [3:0]    grant_o,
    output logic          busy_o,
    output logic [3:0]    ptr_o,
    output logic [CW-1:0] hold_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    grant_q;
    logic          busy_q;
    logic [3:0]    ptr_q;
    logic [CW-1:0] hold_q;

    logic [3:0]    pick_d;
    logic          timeout_d;
    logic          end_d;
    logic [CW-1:0] hold_inc_d;

    if ((MAX_HOLD < 1) || (MAX_HOLD > 255) || (MAX_HOLD > ((2 ** CW) - 1))) begin : g_bad_cfg
        $error("arbitro_rr_onehot: MAX_HOLD does not fit the legal range or CW bits");
    end

    // First requester at or after the pointer position, wrapping 8 -> 1.
    function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [3:0] p);
        logic [3:0] cand;
        logic [3:0] g;
        logic       found;
        cand  = p;
        g     = 4'b0000;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && ((r & cand) != 4'b0000)) begin
                g     = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
            cand = {cand[2:0], cand[3]};
        end
        return g;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Arbitration pick, grant-end decision and saturating hold increment.
    always_comb begin
        pick_d = rr_pick(req_i, ptr_q);
`ifdef ARB_TIMEOUT_EN
        timeout_d = (hold_q == CW'(MAX_HOLD));
`else
        timeout_d = 1'b0;
`endif
        end_d = release_i || ((req_i & grant_q) == 4'b0000) || timeout_d;
        if (hold_q == {CW{1'b1}}) begin
            hold_inc_d = hold_q;
        end else begin
            hold_inc_d = hold_q + CW'(1);
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
            ptr_q   <= 4'b0001;
            hold_q  <= {CW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i != 4'b0000) begin
                        grant_q <= pick_d;
                        state_q <= OWN;
                        busy_q  <= 1'b1;
                        hold_q  <= CW'(1);
                    end else begin
                        // A malformed pointer value is dropped so the ring stays one-hot.
                        if (ptr_load_i && is_onehot(ptr_value_i)) begin
                            ptr_q <= ptr_value_i;
                        end else begin
                            ptr_q <= ptr_q;
                        end
                        grant_q <= 4'b0000;
                        busy_q  <= 1'b0;
                        hold_q  <= {CW{1'b0}};
                    end
                end
                OWN: begin
                    if (end_d) begin
                        grant_q <= 4'b0000;
                        state_q <= GAP;
                        busy_q  <= 1'b1;
                        ptr_q   <= {grant_q[2:0], grant_q[3]};
                        hold_q  <= {CW{1'b0}};
                    end else begin
                        hold_q  <= hold_inc_d;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                    hold_q  <= {CW{1'b0}};
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                    ptr_q   <= 4'b0001;
                    hold_q  <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign ptr_o      = ptr_q;
    assign hold_cnt_o = hold_q;

endmodule

// File: tb/tb_arbitro_rr_onehot.sv
// Bench for arbitro_rr_onehot: directed plan steps then random traffic against an index-based model.
module tb_arbitro_rr_onehot;

    localparam int MAX_HOLD = 8;
    localparam int CW       = 8;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [3:0]    req_i;
    logic          release_i;
    logic          ptr_load_i;
    logic [3:0]    ptr_value_i;
    logic [3:0]    grant_o;
    logic          busy_o;
    logic [3:0]    ptr_o;
    logic [CW-1:0] hold_cnt_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: state 0=idle 1=own 2=gap, owner and pointer as indices 0..3.
    int m_state = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_hold  = 0;

    arbitro_rr_onehot #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_i       (req_i),
        .release_i   (release_i),
        .ptr_load_i  (ptr_load_i),
        .ptr_value_i (ptr_value_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .ptr_o       (ptr_o),
        .hold_cnt_o  (hold_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic rel, input logic ld,
                              input logic [3:0] val, input logic rs);
        bit ended;
        bit found;
        if (!rs) begin
            m_state = 0; m_ptr = 0; m_hold = 0;
        end else if (m_state == 0) begin
            if (r != 4'b0000) begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && r[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                        found   = 1;
                    end
                end
                m_state = 1; m_hold = 1;
            end else if (ld && ($countones(val) == 1)) begin
                for (int b = 0; b < 4; b++) if (val[b]) m_ptr = b;
            end
        end else if (m_state == 1) begin
            ended = rel || !r[m_owner];
`ifdef ARB_TIMEOUT_EN
            if (m_hold == MAX_HOLD) ended = 1;
`endif
            if (ended) begin
                m_state = 2; m_ptr = (m_owner + 1) % 4; m_hold = 0;
            end else begin
                m_hold = (m_hold < 255) ? m_hold + 1 : 255;
            end
        end else begin
            m_state = 0;
        end
    endtask

    task automatic cycle(input string tag, input logic [3:0] r, input logic rel, input logic ld,
                         input logic [3:0] val, input logic rs);
        logic [31:0] exp_g;
        req_i = r; release_i = rel; ptr_load_i = ld; ptr_value_i = val; reset_i = rs;
        @(posedge clk_i);
        model_step(r, rel, ld, val, rs);
        #1;
        exp_g = (m_state == 1) ? (32'd1 << m_owner) : 32'd0;
        check({tag, ".grant"}, 32'(grant_o), exp_g);
        check({tag, ".busy"},  32'(busy_o),  (m_state != 0) ? 32'd1 : 32'd0);
        check({tag, ".ptr"},   32'(ptr_o),   32'd1 << m_ptr);
        check({tag, ".hold"},  32'(hold_cnt_o), 32'(m_hold));
        check({tag, ".onehot0"}, 32'($countones(grant_o) <= 1), 32'd1);
    endtask

    initial begin
        logic [3:0] g;
        // Reset held two cycles with all requesting.
        cycle("rst0", 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0);
        cycle("rst1", 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0);
        check("rst.grant0", 32'(grant_o), 32'd0);
        check("rst.ptr1",   32'(ptr_o),   32'd1);
        cycle("rst_rel", 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1);
        check("first.grant", 32'(grant_o), 32'h1);

        // Rotation through all four requesters.
        g = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            g = {g[2:0], g[3]};
            cycle("rot_rel",  4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1);
            check("rot.gap", 32'(grant_o), 32'd0);
            cycle("rot_idle", 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1);
            cycle("rot_gnt",  4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1);
            check("rot.grant", 32'(grant_o), 32'(g));
        end
        cycle("rot_end",  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1);
        cycle("rot_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);

        // Skip and wrap from pointer 0100.
        cycle("sw_load", 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1);
        cycle("sw_gnt",  4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1);
        check("sw.grant", 32'(grant_o), 32'h1);
        cycle("sw_rel",  4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1);
        check("sw.ptr", 32'(ptr_o), 32'h2);
        cycle("sw_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);

        // Pointer load, illegal load, then arbitration from 1000.
        cycle("pl_load", 4'b0000, 1'b0, 1'b1, 4'b1000, 1'b1);
        cycle("pl_bad",  4'b0000, 1'b0, 1'b1, 4'b0110, 1'b1);
        check("pl.ptr", 32'(ptr_o), 32'h8);
        cycle("pl_gnt",  4'b1001, 1'b0, 1'b1, 4'b0010, 1'b1);
        check("pl.grant", 32'(grant_o), 32'h8);
        cycle("pl_rel",  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1);
        cycle("pl_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);

        // Hold quantum with release never pulsed.
        for (int i = 0; i < 8; i++) cycle("to_own", 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1);
        check("to.hold8", 32'(hold_cnt_o), 32'd8);
`ifdef ARB_TIMEOUT_EN
        cycle("to_end",  4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1);
        check("to.gap", 32'(grant_o), 32'd0);
        cycle("to_idle", 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1);
        cycle("to_next", 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1);
        check("to.next", 32'(grant_o), 32'h2);
`else
        for (int i = 0; i < 252; i++) cycle("to_sat", 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1);
        check("to.sat_hold",  32'(hold_cnt_o), 32'd255);
        check("to.sat_grant", 32'(grant_o), 32'h1);
`endif
        cycle("to_drop", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        cycle("to_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        cycle("to_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);

        // Owner drop, then reset in the middle of a grant.
        cycle("od_gnt",  4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1);
        check("od.grant", 32'(grant_o), 32'h4);
        cycle("od_drop", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        check("od.gap_busy", 32'(busy_o), 32'd1);
        cycle("od_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1);
        cycle("mr_gnt",  4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1);
        cycle("mr_rst",  4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0);
        check("mr.grant", 32'(grant_o), 32'd0);
        check("mr.ptr",   32'(ptr_o),   32'h1);
        cycle("mr_after", 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle("rand",
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 63) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arbitro_rr_onehot.md
Name: arbitro_rr_onehot

Overview:
- Round-robin arbiter that shares one resource among 4 requesters.
- Priority pointer is a one-hot ring that rotates 1->2->4->8->1.
- Issues a registered one-hot grant, limits hold time with a quantum counter, and inserts a one-cycle turnaround gap between owners.
- Sits in front of a shared sequential datapath and decides which client drives it each cycle.

Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles per owner. Legal range 1..255.
- CW, default 8: quantum counter width. MAX_HOLD must fit in CW bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- req  input  4  request vector; bit i = requester i.
- release  input  1  current owner finished; sampled only in state OWN.
- ptr_load  input  1  load priority pointer; honoured only in state IDLE.
- ptr_value  input  4  new pointer value; must be one-hot.
- grant  output  4  registered one-hot grant, or 0.
- busy  output  1  high when state is OWN or GAP.
- ptr  output  4  current one-hot priority pointer.
- hold_cnt  output  CW  grant cycles elapsed for the current owner.

Behaviour:
- Reset is synchronous and active-low: reset is sampled low at a rising edge of clk. On that edge: state=IDLE, grant=0, busy=0, ptr=4'b0001, hold_cnt=0. Reset has priority over every other input.
- States: IDLE, OWN, GAP.
- IDLE:
  - If req!=0, select the first set bit of req scanning from ptr upward with wrap (order ptr, ptr<<1, ..., 8 wraps to 1).
  - Next edge: grant=selected bit, state=OWN, hold_cnt=1.
  - Latency from req to grant is 1 cycle.
- IDLE with req==0 and ptr_load=1:
  - If ptr_value is exactly one-hot, ptr<=ptr_value. Otherwise the load is ignored and ptr is unchanged.
- IDLE with req!=0 and ptr_load=1 on the same edge:
  - Arbitration uses the old ptr. The load is ignored.
- ptr_load is ignored in OWN and GAP.
- OWN:
  - The grant ends when any of these is true: release=1; the owner's req bit is 0; hold_cnt==MAX_HOLD (when ARB_TIMEOUT_EN is defined).
  - On that edge: grant=0, state=GAP, ptr = rotate-left of the granted bit (8->1), hold_cnt=0.
  - Otherwise grant holds and hold_cnt increments, saturating at 2^CW-1.
  - If several end conditions are true in the same cycle, the result is identical to any one of them alone.
- GAP:
  - Lasts exactly 1 cycle with grant=0, then state=IDLE.
  - Requests present during GAP are arbitrated in IDLE on the next cycle.
  - Back-to-back owners are therefore spaced 2 cycles apart: OWN end edge -> GAP -> IDLE -> grant.
- busy is a registered output and equals (state!=IDLE).
- Invariants:
  - grant always has at most one bit set.
  - grant is never set for a requester whose req was 0 at the arbitration edge.
- A requester that keeps req high is served again only after every other active requester has had one turn (fairness through pointer rotation).
- If reset is asserted while in OWN, grant goes to 0 on that edge. No GAP cycle is inserted.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: an owner whose grant reaches hold_cnt==MAX_HOLD loses the grant on that edge, even if req and release are unchanged. This is treated as an ordinary grant end, so the pointer rotates.
- Undefined: the MAX_HOLD comparison is not compiled in. The grant ends only on release or when the owner drops req. hold_cnt still counts and saturates as a debug aid.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req=4'b1111 -> grant=0, busy=0, ptr=4'b0001, hold_cnt=0. Release reset -> next edge grant=4'b0001.
- Rotation: req=4'b1111 held constant and release pulsed 1 cycle after each grant -> grants 0001,0010,0100,1000,0001 in turn, with a GAP cycle (grant=0) between each.
- Skip and wrap: ptr=4'b0100, req=4'b0011 -> grant=4'b0001. After release, ptr=4'b0010.
- Pointer load: in IDLE with req=0, ptr_value=4'b1000 -> ptr=1000. Then ptr_value=4'b0110 -> ptr unchanged at 1000. Then req=4'b1001 -> grant=4'b1000.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req=4'b0011, release never pulsed -> grant=0001 for exactly 8 cycles, GAP for 1 cycle, then grant=0010. Without the macro -> grant=0001 held indefinitely and hold_cnt saturates at 255.
- Owner drop and mid-grant reset: owner drops req in OWN -> GAP on the next edge. Reset=0 asserted in OWN -> grant=0 and ptr=0001 on that edge.
